cpu_run_ctrl: RTL

Run-control sequencer for the picorv32 instruction stream on the board top level. It sits between the address-decoded `mem_ready` and the CPU. It holds, single-steps, free-runs or breakpoint-halts the core by withholding `mem_ready` on instruction fetches only. Inputs are debounced front-panel buttons and the slide-switch breakpoint address. It replaces the ad-hoc stop/run/step logic in the system top.

---
 rtl/cpu_run_ctrl_pkg.sv | 14 +
 rtl/cpu_run_ctrl_btn_debounce.sv | 49 ++++
 rtl/cpu_run_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared types and parameter defaults for the run-control sequencer
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_STOP = 2'd0,
    RC_RUN  = 2'd1,
    RC_STEP = 2'd2
  } rc_state_t;

  localparam int DEBOUNCE_LOG_DEF = 18;
  localparam int HOLD_TICKS_DEF   = 127;
  localparam int BP_W_DEF         = 16;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// rtl/cpu_run_ctrl_btn_debounce.sv - button synchronizer, tick-sampled level, press pulse and long-press detect
module btn_debounce #(
  parameter int HOLD_TICKS = 127
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic btn,
  output logic press,
  output logic long_press
);

  localparam int CW = $clog2(HOLD_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      press      <= 1'b0;
      long_press <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      press      <= 1'b0;
      long_press <= 1'b0;
      if (tick) begin
        level <= sync2;
        press <= sync2 & ~level;
        // Saturating count, so long_press fires exactly once per hold
        if (sync2) begin
          if (hold_cnt < CW'(HOLD_TICKS)) begin
            hold_cnt   <= hold_cnt + 1'b1;
            long_press <= (hold_cnt == CW'(HOLD_TICKS - 1));
          end
        end else begin
          hold_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - holds, steps, runs or breakpoint-halts the core by gating instruction-fetch ready
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LOG = DEBOUNCE_LOG_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int BP_W         = BP_W_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            btn_stop,
  input  logic            btn_run,
  input  logic            btn_step,
  input  logic            bp_en,
  input  logic [BP_W-1:0] bp_addr,
  input  logic            mem_valid,
  input  logic            mem_instr,
  input  logic [31:0]     mem_addr,
  input  logic            gate_en,
  input  logic            mem_ready_in,
  output logic            mem_ready,
  output rc_state_t       state,
  output logic            halted,
  output logic            bp_hit,
  output logic [31:0]     fetch_count
);

  logic [DEBOUNCE_LOG-1:0] div_cnt;
  logic                    tick;
  logic                    stop_press, run_press, step_press, step_long;
  logic                    unused_stop_long, unused_run_long;
  logic [31-BP_W:0]        unused_addr_hi;
  logic                    skip_bp;
  logic                    gated_fetch, bp_match, block, fetch_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_cnt <= '0;
    else         div_cnt <= div_cnt + 1'b1;
  end

  assign tick = &div_cnt;

  btn_debounce #(.HOLD_TICKS(HOLD_TICKS)) u_stop (
    .clk(clk), .resetn(resetn), .tick(tick), .btn(btn_stop),
    .press(stop_press), .long_press(unused_stop_long)
  );

  btn_debounce #(.HOLD_TICKS(HOLD_TICKS)) u_run (
    .clk(clk), .resetn(resetn), .tick(tick), .btn(btn_run),
    .press(run_press), .long_press(unused_run_long)
  );

  btn_debounce #(.HOLD_TICKS(HOLD_TICKS)) u_step (
    .clk(clk), .resetn(resetn), .tick(tick), .btn(btn_step),
    .press(step_press), .long_press(step_long)
  );

  assign unused_addr_hi = mem_addr[31:BP_W];

  assign gated_fetch = mem_valid & mem_instr & gate_en;
  assign bp_match    = gated_fetch & bp_en & (mem_addr[BP_W-1:0] == bp_addr) & ~skip_bp;

  // A stop press blocks the fetch it coincides with, so a stepping fetch cannot slip through
  assign block = gated_fetch & ((state == RC_STOP) | stop_press |
                                ((state == RC_RUN) & bp_match));

  assign mem_ready  = block ? 1'b0 : mem_ready_in;
  assign fetch_done = gated_fetch & mem_ready;
  assign halted     = (state == RC_STOP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RC_STOP;
      bp_hit      <= 1'b0;
      skip_bp     <= 1'b1;
      fetch_count <= '0;
    end else begin
      bp_hit <= 1'b0;
      if (fetch_done) fetch_count <= fetch_count + 32'd1;

      if (stop_press) begin
        state <= RC_STOP;
      end else if (run_press | step_long) begin
        state   <= RC_RUN;
        skip_bp <= 1'b1;
      end else if (step_press && state == RC_STOP) begin
        state   <= RC_STEP;
        skip_bp <= 1'b1;
      end else begin
        // Resuming at the breakpoint address must not re-trigger until one fetch completes
        if (fetch_done) skip_bp <= 1'b0;
        if (state == RC_RUN && bp_match) begin
          state  <= RC_STOP;
          bp_hit <= 1'b1;
        end else if (state == RC_STEP && fetch_done) begin
          state <= RC_STOP;
        end
      end
    end
  end

endmodule
